// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MIPS32 MEM stage: one load/store at a time,
// fixed access latency, valid/ready on both request and response channels.
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit         LAT_ONE  = (LAT == 1);
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] mem_r [DEPTH];

    logic          accept_s;
    logic          enter_resp_s;
    logic          acc_we_s;
    logic [31:0]   acc_addr_s;
    logic [31:0]   acc_wdata_s;
    logic [AW-1:0] acc_idx_s;
    logic          in_range_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   rsp_rdata_s;

    // Access operands: live request when LAT==1 enters RESP straight from IDLE, else the captured copy
    always_comb begin
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        acc_we_s     = we_r;
        acc_addr_s   = addr_r;
        acc_wdata_s  = wdata_r;
        case (state_r)
            IDLE: begin
                accept_s     = req_valid && req_ready;
                enter_resp_s = accept_s && LAT_ONE;
                acc_we_s     = req_we;
                acc_addr_s   = req_addr;
                acc_wdata_s  = req_wdata;
            end
            WAIT: begin
                enter_resp_s = (cnt_r == 4'd0);
            end
            default: begin
                enter_resp_s = 1'b0;
            end
        endcase
        acc_idx_s  = acc_addr_s[AW-1:0];
        in_range_s = (acc_addr_s < 32'(DEPTH));
        rd_word_s  = mem_r[acc_idx_s];
        if (!acc_we_s && in_range_s) begin
            rsp_rdata_s = rd_word_s;
        end else begin
            rsp_rdata_s = 32'd0;
        end
    end

    // Array write on the RESP-entry edge; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (enter_resp_s && acc_we_s && in_range_s) begin
            mem_r[acc_idx_s] <= acc_wdata_s;
        end
    end

    // Request/response FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            we_r      <= 1'b0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r      <= req_we;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt_r     <= CNT_LOAD;
                        if (enter_resp_s) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_rdata_s;
                            rsp_err   <= !in_range_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (enter_resp_s) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_rdata_s;
                        rsp_err   <= !in_range_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
